// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and address-width helper for the register file
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    // Address width for a given register count; never below 1 bit.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: x0 forcing, write bypass mux, busy gating
//
// Ports:
//   addr_i    read address
//   stored_i  value currently held in the addressed register
//   busy_i    scoreboard bit of the addressed register
//   wren_i / waddr_i / wdata_i   all write ports, flattened (port p at slice p)
//   data_o    operand value
//   busy_o    operand still waiting on a producer
module regfile_rd_port #(
    parameter int XLEN   = 32,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = 5
) (
    input  logic [AW-1:0]       addr_i,
    input  logic [XLEN-1:0]     stored_i,
    input  logic                busy_i,
    input  logic [NWR-1:0]      wren_i,
    input  logic [NWR*AW-1:0]   waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    output logic [XLEN-1:0]     data_o,
    output logic                busy_o
);

    logic            hit;
    logic            hit_en;
    logic [XLEN-1:0] byp_data;

    always_comb begin
        hit      = 1'b0;
        byp_data = '0;
        // Ascending scan: the last (highest-index) hitting port overrides earlier ones.
        for (int p = 0; p < NWR; p++) begin
            if (wren_i[p] && (waddr_i[p*AW +: AW] == addr_i)) begin
                hit      = 1'b1;
                byp_data = wdata_i[p*XLEN +: XLEN];
            end
        end
        hit_en = (BYPASS != 0) && hit;

        if (addr_i == '0) begin
            data_o = '0;
        end else if (hit_en) begin
            data_o = byp_data;
        end else begin
            data_o = stored_i;
        end

        // A value being written right now is already available through the bypass.
        busy_o = busy_i & ~hit_en;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and busy scoreboard
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rs_addr_i / rs_data_o / rs_busy_o   NRD read ports (flattened), combinational
//   rd_wren_i / rd_addr_i / rd_data_i   NWR write ports (flattened), commit on posedge
//   iss_vld_i / iss_rd_i  issue marks destination busy
//   busy_o                full scoreboard vector
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic [NWR-1:0]      rd_wren_i,
    input  logic [NWR*AW-1:0]   rd_addr_i,
    input  logic [NWR*XLEN-1:0] rd_data_i,
    input  logic                iss_vld_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic [DEPTH-1:0]    busy_o
);

    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [XLEN-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++) begin
            if (rd_wren_i[p]) begin
                regs_d[rd_addr_i[p*AW +: AW]] = rd_data_i[p*XLEN +: XLEN];
            end
        end
        // Writes to x0 land here and are discarded.
        regs_d[0] = '0;
    end

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (rd_wren_i[p]) begin
                busy_d[rd_addr_i[p*AW +: AW]] = 1'b0;
            end
        end
        // Applied after the clears so a new producer overrides an old writeback.
        if (iss_vld_i) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rs_addr_i[k*AW +: AW];

        regfile_rd_port #(
            .XLEN   (XLEN),
            .NWR    (NWR),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd_port (
            .addr_i   (addr),
            .stored_i (regs_q[addr]),
            .busy_i   (busy_q[addr]),
            .wren_i   (rd_wren_i),
            .waddr_i  (rd_addr_i),
            .wdata_i  (rd_data_i),
            .data_o   (rs_data_o[k*XLEN +: XLEN]),
            .busy_o   (rs_busy_o[k])
        );
    end

endmodule
